// File: rtl/uart_rx_if.sv
// uart_rx_if: serial input and received-byte outputs of the UART receiver
interface uart_rx_if;
  logic rx;
  logic [7:0] data;
  logic valid;
  logic frame_err;
  logic busy;
  modport master (output rx, input data, valid, frame_err, busy);
  modport slave (input rx, output data, valid, frame_err, busy);
endinterface

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with mid-bit sampling and framing-error detection
module uart_rx #(
  parameter int unsigned CLKS_PER_BIT = 414
) (
  input logic CLKIN,
  input logic RESETN,
  uart_rx_if.slave u
);
  localparam logic [15:0] H = 16'(CLKS_PER_BIT / 2);
  localparam logic [15:0] N = 16'(CLKS_PER_BIT);
  localparam logic [2:0] IDLE = 3'd0, START = 3'd1, DATA = 3'd2, STOP = 3'd3, BREAK = 3'd4;
  logic [2:0] state;
  logic [15:0] cnt;
  logic [2:0] idx;
  logic [7:0] sr;
  logic [7:0] data;
  logic [1:0] sync;
  logic valid;
  logic frame_err;
  logic rx_s;
  logic hit;
  assign rx_s = sync[1];
  // START waits half a bit to land on mid-bit; later states wait a full bit
  assign hit = cnt == ((state == START) ? H - 16'd1 : N - 16'd1);
  always_ff @(posedge CLKIN or negedge RESETN)
    if (!RESETN) begin
      sync <= 2'b11;
      state <= IDLE;
      cnt <= '0;
      idx <= '0;
      sr <= '0;
      data <= '0;
      valid <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      sync <= {sync[0], u.rx};
      valid <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        IDLE: if (!rx_s) begin
          state <= START;
          cnt <= '0;
        end
        START: if (!hit) cnt <= cnt + 16'd1;
        else if (!rx_s) begin
          state <= DATA;
          cnt <= '0;
          idx <= '0;
        end else state <= IDLE;
        DATA: if (!hit) cnt <= cnt + 16'd1;
        else begin
          sr <= {rx_s, sr[7:1]};
          cnt <= '0;
          idx <= idx + 3'd1;
          if (idx == 3'd7) state <= STOP;
        end
        STOP: if (!hit) cnt <= cnt + 16'd1;
        else begin
          cnt <= '0;
          if (rx_s) begin
            data <= sr;
            valid <= 1'b1;
            state <= IDLE;
          end else begin
            frame_err <= 1'b1;
            state <= BREAK;
          end
        end
        BREAK: if (rx_s) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  assign u.data = data;
  assign u.valid = valid;
  assign u.frame_err = frame_err;
  assign u.busy = state != IDLE;
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: scoreboard bench for uart_rx at 16 and 414 clocks per bit
module tb_uart_rx;
  typedef struct {
    bit fe;
    logic [7:0] d;
    int cyc;
  } exp_t;
  logic CLKIN = 1'b0;
  logic RESETN = 1'b0;
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  exp_t qa[$];
  exp_t qb[$];
  exp_t ea, eb;
  uart_rx_if ia ();
  uart_rx_if ib ();
  uart_rx #(.CLKS_PER_BIT(16)) dut_a (.CLKIN(CLKIN), .RESETN(RESETN), .u(ia.slave));
  uart_rx dut_b (.CLKIN(CLKIN), .RESETN(RESETN), .u(ib.slave));
  always #5 CLKIN = ~CLKIN;
  always @(posedge CLKIN) cyc++;
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d", name, act, act, exp, exp, cyc);
    end
  endtask
  always @(negedge CLKIN) if (RESETN) begin
    if (ia.valid) chk("a_exclusive", int'(ia.frame_err), 0);
    if (ia.valid || ia.frame_err) begin
      if (qa.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL a_unexpected: pulse valid=%0b frame_err=%0b data=0x%0h, none expected, cycle %0d", ia.valid, ia.frame_err, ia.data, cyc);
      end else begin
        ea = qa.pop_front();
        chk("a_kind_frame_err", int'(ia.frame_err), int'(ea.fe));
        chk("a_data", int'(ia.data), int'(ea.d));
        chk("a_cycle", cyc, ea.cyc);
      end
    end
  end
  always @(negedge CLKIN) if (RESETN) begin
    if (ib.valid) chk("b_exclusive", int'(ib.frame_err), 0);
    if (ib.valid || ib.frame_err) begin
      if (qb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL b_unexpected: pulse valid=%0b frame_err=%0b data=0x%0h, none expected, cycle %0d", ib.valid, ib.frame_err, ib.data, cyc);
      end else begin
        eb = qb.pop_front();
        chk("b_kind_frame_err", int'(ib.frame_err), int'(eb.fe));
        chk("b_data", int'(ib.data), int'(eb.d));
        chk("b_cycle", cyc, eb.cyc);
      end
    end
  end
  // Called at a negedge; the next posedge is E0 and each bit lasts n cycles
  task automatic send(input logic [7:0] d, input bit stop, input int n, input bit sel);
    logic [9:0] bits;
    bits = {stop, d, 1'b0};
    for (int i = 0; i < 10; i++) begin
      if (sel) ib.rx = bits[i];
      else ia.rx = bits[i];
      repeat (n) @(negedge CLKIN);
    end
  endtask
  initial begin
    int e0;
    logic [9:0] bits;
    ia.rx = 1'b1;
    ib.rx = 1'b1;
    #1;
    chk("reset_data", int'(ia.data), 0);
    chk("reset_busy", int'(ia.busy), 0);
    chk("reset_valid", int'(ia.valid), 0);
    repeat (3) @(negedge CLKIN);
    RESETN = 1'b1;
    repeat (4) @(negedge CLKIN);
    e0 = cyc + 1;
    qa.push_back('{0, 8'hA5, e0 + 154});
    send(8'hA5, 1'b1, 16, 1'b0);
    repeat (6) @(negedge CLKIN);
    e0 = cyc + 1;
    qa.push_back('{0, 8'h00, e0 + 154});
    qa.push_back('{0, 8'hFF, e0 + 314});
    send(8'h00, 1'b1, 16, 1'b0);
    send(8'hFF, 1'b1, 16, 1'b0);
    repeat (6) @(negedge CLKIN);
    e0 = cyc + 1;
    ia.rx = 1'b0;
    repeat (5) @(negedge CLKIN);
    ia.rx = 1'b1;
    chk("glitch_busy_high", int'(ia.busy), 1);
    repeat (6) @(negedge CLKIN);
    chk("glitch_busy_low", int'(ia.busy), 0);
    repeat (6) @(negedge CLKIN);
    e0 = cyc + 1;
    qa.push_back('{1, 8'hFF, e0 + 154});
    send(8'h3C, 1'b0, 16, 1'b0);
    repeat (40) @(negedge CLKIN);
    chk("break_busy", int'(ia.busy), 1);
    chk("break_data_held", int'(ia.data), 8'hFF);
    ia.rx = 1'b1;
    repeat (4) @(negedge CLKIN);
    e0 = cyc + 1;
    qa.push_back('{0, 8'h81, e0 + 154});
    send(8'h81, 1'b1, 16, 1'b0);
    repeat (6) @(negedge CLKIN);
    bits = {1'b1, 8'h55, 1'b0};
    for (int i = 0; i < 6; i++) begin
      ia.rx = bits[i];
      repeat (i == 5 ? 8 : 16) @(negedge CLKIN);
    end
    RESETN = 1'b0;
    #1;
    chk("midreset_data", int'(ia.data), 0);
    chk("midreset_busy", int'(ia.busy), 0);
    chk("midreset_valid", int'(ia.valid), 0);
    chk("midreset_frame_err", int'(ia.frame_err), 0);
    ia.rx = 1'b1;
    repeat (3) @(negedge CLKIN);
    RESETN = 1'b1;
    repeat (5) @(negedge CLKIN);
    e0 = cyc + 1;
    qa.push_back('{0, 8'h12, e0 + 154});
    send(8'h12, 1'b1, 16, 1'b0);
    repeat (6) @(negedge CLKIN);
    e0 = cyc + 1;
    qb.push_back('{0, 8'hC3, e0 + 2 + 207 + 3726});
    send(8'hC3, 1'b1, 414, 1'b1);
    repeat (20) @(negedge CLKIN);
    chk("a_pending_left", qa.size(), 0);
    chk("b_pending_left", qb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
